// File: rtl/int_sched_pkg.sv
// int_sched_pkg: shared definitions for the machine-mode interrupt scheduler.
// mip/mie bit positions, mcause codes, the mstatus.MIE index and the FSM state encoding.
package int_sched_pkg;

    localparam int unsigned XLEN            = 64;
    localparam int unsigned MIP_MEI_BIT     = 11;
    localparam int unsigned MIP_MTI_BIT     = 7;
    localparam int unsigned MIP_MSI_BIT     = 3;
    localparam int unsigned MSTATUS_MIE_BIT = 3;

    localparam logic [XLEN-1:0] CAUSE_MEI = 64'h8000_0000_0000_000B;
    localparam logic [XLEN-1:0] CAUSE_MSI = 64'h8000_0000_0000_0003;
    localparam logic [XLEN-1:0] CAUSE_MTI = 64'h8000_0000_0000_0007;

    // One-hot request FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_BUSY = 3'b100
    } state_t;

    // Compact pending/eligible vector, one bit per source
    typedef struct packed {
        logic mei;
        logic msi;
        logic mti;
    } irq_vec_t;

endpackage

// File: rtl/int_sched_if.sv
// int_sched_if: bundle between interrupt sources/CSRs/CLINT and the scheduler.
// master = environment side (sources, CSR file, CLINT); slave = int_sched.
interface int_sched_if;
    import int_sched_pkg::*;

    logic            irq_ext_i;
    logic            irq_sw_i;
    logic            irq_timer_i;
    logic [XLEN-1:0] csr_mie;
    logic [XLEN-1:0] csr_mstatus;
    logic            int_ack_i;
    logic            mret_i;
    logic            int_req_o;
    logic [XLEN-1:0] int_cause_o;
    logic [XLEN-1:0] mip_o;

    modport master (
        output irq_ext_i, irq_sw_i, irq_timer_i, csr_mie, csr_mstatus, int_ack_i, mret_i,
        input  int_req_o, int_cause_o, mip_o
    );

    modport slave (
        input  irq_ext_i, irq_sw_i, irq_timer_i, csr_mie, csr_mstatus, int_ack_i, mret_i,
        output int_req_o, int_cause_o, mip_o
    );

endinterface

// File: rtl/int_sched_prio_enc.sv
// int_prio_enc: fixed-priority encoder MEI > MSI > MTI producing a valid flag and mcause.
module int_prio_enc
    import int_sched_pkg::*;
(
    input  irq_vec_t        i_elig,
    output logic            o_valid,
    output logic [XLEN-1:0] o_cause
);

    // Pick the highest-priority eligible source
    always_comb begin
        o_valid = 1'b1;
        o_cause = '0;
        if (i_elig.mei)      o_cause = CAUSE_MEI;
        else if (i_elig.msi) o_cause = CAUSE_MSI;
        else if (i_elig.mti) o_cause = CAUSE_MTI;
        else                 o_valid = 1'b0;
    end

endmodule

// File: rtl/int_sched.sv
// int_sched: latches interrupt lines into mip, masks with mie/mstatus.MIE and
// presents one stable request to the CLINT until mret.
// Optional feature: `define INT_SCHED_EXT_EDGE_EN makes MEI edge-triggered
// (set on a rising edge of irq_ext_i, cleared when the MEI request is acked).
module int_sched
    import int_sched_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    int_sched_if.slave bus
);

    irq_vec_t        r_mip;
    state_t          r_state;
    logic            r_req;
    logic [XLEN-1:0] r_cause;

    irq_vec_t        w_elig;
    logic            w_valid;
    logic [XLEN-1:0] w_cause;
    logic            w_mie_glb;
    logic            w_unused_csr;

    // Only three mie bits and one mstatus bit matter here
    assign w_unused_csr = ^{bus.csr_mie, bus.csr_mstatus};

    assign w_mie_glb  = bus.csr_mstatus[MSTATUS_MIE_BIT];
    assign w_elig.mei = w_mie_glb & r_mip.mei & bus.csr_mie[MIP_MEI_BIT];
    assign w_elig.msi = w_mie_glb & r_mip.msi & bus.csr_mie[MIP_MSI_BIT];
    assign w_elig.mti = w_mie_glb & r_mip.mti & bus.csr_mie[MIP_MTI_BIT];

    int_prio_enc u_prio_enc (
        .i_elig  (w_elig),
        .o_valid (w_valid),
        .o_cause (w_cause)
    );

`ifdef INT_SCHED_EXT_EDGE_EN
    logic r_ext_d;
    logic w_ext_rise;
    logic w_mei_clr;

    assign w_ext_rise = bus.irq_ext_i & ~r_ext_d;
    assign w_mei_clr  = (r_state == ST_REQ) && bus.int_ack_i && (r_cause == CAUSE_MEI);

    // Pending latch: MEI edge-set / ack-cleared (set wins), MSI/MTI level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_d <= 1'b0;
            r_mip   <= '0;
        end else begin
            r_ext_d   <= bus.irq_ext_i;
            r_mip.msi <= bus.irq_sw_i;
            r_mip.mti <= bus.irq_timer_i;
            if (w_ext_rise)     r_mip.mei <= 1'b1;
            else if (w_mei_clr) r_mip.mei <= 1'b0;
        end
    end
`else
    // Pending latch: all sources level-sensitive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mip <= '0;
        end else begin
            r_mip.mei <= bus.irq_ext_i;
            r_mip.msi <= bus.irq_sw_i;
            r_mip.mti <= bus.irq_timer_i;
        end
    end
`endif

    // Request FSM with registered request and locked cause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_cause <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_cause <= w_cause;
                    end
                end
                ST_REQ: begin
                    // Ack takes precedence over a simultaneous loss of eligibility
                    if (bus.int_ack_i) begin
                        r_state <= ST_BUSY;
                        r_req   <= 1'b0;
                    end else if (!w_valid) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        r_cause <= '0;
                    end
                end
                ST_BUSY: begin
                    if (bus.mret_i) begin
                        r_state <= ST_IDLE;
                        r_cause <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_cause <= '0;
                end
            endcase
        end
    end

    assign bus.int_req_o   = r_req;
    assign bus.int_cause_o = r_cause;

    // Map the compact pending vector onto the architectural mip layout
    always_comb begin
        bus.mip_o              = '0;
        bus.mip_o[MIP_MEI_BIT] = r_mip.mei;
        bus.mip_o[MIP_MTI_BIT] = r_mip.mti;
        bus.mip_o[MIP_MSI_BIT] = r_mip.msi;
    end

endmodule

// File: tb/tb_int_sched.sv
// tb_int_sched: scenario-driven bench for int_sched. Expected causes are queued
// when a source is driven and popped when the DUT raises its request.
module tb_int_sched;

    localparam logic [63:0] C_MEI   = 64'h8000_0000_0000_000B;
    localparam logic [63:0] C_MSI   = 64'h8000_0000_0000_0003;
    localparam logic [63:0] C_MTI   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] MIE_ALL = 64'h0000_0000_0000_0888;
    localparam logic [63:0] MST_ON  = 64'h0000_0000_0000_0008;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp;
    bit          found;

    int_sched_if bus ();

    int_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.int_req_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pop_exp(output logic [63:0] e);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = 64'hDEAD_DEAD_DEAD_DEAD;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.irq_ext_i = 0; bus.irq_sw_i = 0; bus.irq_timer_i = 0;
        bus.csr_mie = '0; bus.csr_mstatus = '0;
        bus.int_ack_i = 0; bus.mret_i = 0;
        tick(); tick();
        vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", bus.int_req_o); end
        vectors++; if (bus.int_cause_o !== 64'h0) begin miscompares++; $display("FAIL reset_cause: got %h want 0", bus.int_cause_o); end
        vectors++; if (bus.mip_o !== 64'h0) begin miscompares++; $display("FAIL reset_mip: got %h want 0", bus.mip_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_timer();
        bus.csr_mie = MIE_ALL; bus.csr_mstatus = MST_ON;
        bus.irq_timer_i = 1; exp_q.push_back(C_MTI);
        tick();
        vectors++; if (bus.mip_o !== 64'h80) begin miscompares++; $display("FAIL timer_mip: got %h want 80", bus.mip_o); end
        vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL timer_req_early: got %b want 0", bus.int_req_o); end
        tick();
        vectors++; if (bus.int_req_o !== 1'b1) begin miscompares++; $display("FAIL timer_req: got %b want 1", bus.int_req_o); end
        pop_exp(exp);
        vectors++; if (bus.int_cause_o !== exp) begin miscompares++; $display("FAIL timer_cause: got %h want %h", bus.int_cause_o, exp); end
        bus.int_ack_i = 1; tick(); bus.int_ack_i = 0;
        vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL timer_ack_req: got %b want 0", bus.int_req_o); end
        vectors++; if (bus.int_cause_o !== C_MTI) begin miscompares++; $display("FAIL timer_busy_cause: got %h want %h", bus.int_cause_o, C_MTI); end
        bus.irq_timer_i = 0; tick();
        bus.mret_i = 1; tick(); bus.mret_i = 0;
        vectors++; if (bus.int_cause_o !== 64'h0) begin miscompares++; $display("FAIL timer_mret_cause: got %h want 0", bus.int_cause_o); end
        tick();
        vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL timer_idle_req: got %b want 0", bus.int_req_o); end
    endtask

    task automatic test_priority();
        bus.irq_ext_i = 1; bus.irq_sw_i = 1; bus.irq_timer_i = 1;
        exp_q.push_back(C_MEI); exp_q.push_back(C_MSI); exp_q.push_back(C_MTI);
        for (int i = 0; i < 3; i++) begin
            wait_req(6, found);
            vectors++; if (!found) begin miscompares++; $display("FAIL prio_timeout[%0d]: got no request want request", i); end
            pop_exp(exp);
            vectors++; if (bus.int_cause_o !== exp) begin miscompares++; $display("FAIL prio_cause[%0d]: got %h want %h", i, bus.int_cause_o, exp); end
            bus.int_ack_i = 1; tick(); bus.int_ack_i = 0;
            if (i == 0) bus.irq_ext_i = 0;
            else if (i == 1) bus.irq_sw_i = 0;
            else bus.irq_timer_i = 0;
            tick();
            bus.mret_i = 1; tick(); bus.mret_i = 0;
            vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL prio_gap[%0d]: got %b want 0", i, bus.int_req_o); end
        end
    endtask

    task automatic test_mie_drop();
        // Pending but masked by mie: no request
        bus.csr_mie = 64'h880; bus.irq_sw_i = 1;
        tick(); tick(); tick();
        vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL masked_req: got %b want 0", bus.int_req_o); end
        vectors++; if (bus.mip_o !== 64'h8) begin miscompares++; $display("FAIL masked_mip: got %h want 8", bus.mip_o); end
        bus.irq_sw_i = 0; bus.csr_mie = MIE_ALL;
        bus.irq_timer_i = 1; exp_q.push_back(C_MTI);
        tick(); tick();
        vectors++; if (bus.int_req_o !== 1'b1) begin miscompares++; $display("FAIL drop_req_up: got %b want 1", bus.int_req_o); end
        bus.csr_mstatus = '0; tick();
        vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL drop_req: got %b want 0", bus.int_req_o); end
        vectors++; if (bus.int_cause_o !== 64'h0) begin miscompares++; $display("FAIL drop_cause: got %h want 0", bus.int_cause_o); end
        // Back in IDLE: re-enabling raises a request on the next edge
        bus.csr_mstatus = MST_ON; tick();
        pop_exp(exp);
        vectors++; if (bus.int_req_o !== 1'b1 || bus.int_cause_o !== exp) begin miscompares++; $display("FAIL drop_reraise: got %b/%h want 1/%h", bus.int_req_o, bus.int_cause_o, exp); end
        // Ack together with loss of eligibility: ack wins
        bus.int_ack_i = 1; bus.csr_mstatus = '0; tick(); bus.int_ack_i = 0;
        vectors++; if (bus.int_req_o !== 1'b0 || bus.int_cause_o !== C_MTI) begin miscompares++; $display("FAIL ack_vs_drop: got %b/%h want 0/%h", bus.int_req_o, bus.int_cause_o, C_MTI); end
        bus.irq_timer_i = 0;
        bus.mret_i = 1; tick(); bus.mret_i = 0;
        bus.csr_mstatus = MST_ON; tick();
    endtask

    task automatic test_preempt_hold();
        bus.irq_timer_i = 1; exp_q.push_back(C_MTI);
        tick(); tick();
        pop_exp(exp);
        vectors++; if (bus.int_req_o !== 1'b1 || bus.int_cause_o !== exp) begin miscompares++; $display("FAIL hold_first: got %b/%h want 1/%h", bus.int_req_o, bus.int_cause_o, exp); end
        bus.irq_ext_i = 1; exp_q.push_back(C_MEI);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.int_cause_o !== C_MTI || bus.int_req_o !== 1'b1) begin miscompares++; $display("FAIL hold_stable[%0d]: got %b/%h want 1/%h", i, bus.int_req_o, bus.int_cause_o, C_MTI); end
        end
        bus.int_ack_i = 1; tick(); bus.int_ack_i = 0;
        bus.irq_timer_i = 0; tick();
        bus.mret_i = 1; tick(); bus.mret_i = 0;
        vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL hold_mret_idle: got %b want 0", bus.int_req_o); end
        tick();
        pop_exp(exp);
        vectors++; if (bus.int_req_o !== 1'b1 || bus.int_cause_o !== exp) begin miscompares++; $display("FAIL hold_next: got %b/%h want 1/%h", bus.int_req_o, bus.int_cause_o, exp); end
        bus.int_ack_i = 1; tick(); bus.int_ack_i = 0;
        bus.irq_ext_i = 0; tick();
        bus.mret_i = 1; tick(); bus.mret_i = 0;
        tick();
    endtask

    task automatic test_async_reset();
        bus.irq_timer_i = 1; bus.irq_sw_i = 1; exp_q.push_back(C_MSI);
        wait_req(6, found);
        vectors++; if (!found) begin miscompares++; $display("FAIL arst_timeout: got no request want request"); end
        bus.int_ack_i = 1; tick(); bus.int_ack_i = 0;
        pop_exp(exp);
        vectors++; if (bus.int_cause_o !== exp) begin miscompares++; $display("FAIL arst_busy_cause: got %h want %h", bus.int_cause_o, exp); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.int_req_o !== 1'b0 || bus.int_cause_o !== 64'h0 || bus.mip_o !== 64'h0) begin miscompares++; $display("FAIL arst_now: got %b/%h/%h want 0/0/0", bus.int_req_o, bus.int_cause_o, bus.mip_o); end
        tick();
        rst = 1'b0; exp_q.push_back(C_MSI);
        tick();
        vectors++; if (bus.int_req_o !== 1'b0 || bus.mip_o !== 64'h88) begin miscompares++; $display("FAIL arst_mip: got %b/%h want 0/88", bus.int_req_o, bus.mip_o); end
        tick();
        pop_exp(exp);
        vectors++; if (bus.int_req_o !== 1'b1 || bus.int_cause_o !== exp) begin miscompares++; $display("FAIL arst_reraise: got %b/%h want 1/%h", bus.int_req_o, bus.int_cause_o, exp); end
        bus.int_ack_i = 1; tick(); bus.int_ack_i = 0;
        bus.irq_timer_i = 0; bus.irq_sw_i = 0; tick();
        bus.mret_i = 1; tick(); bus.mret_i = 0;
        tick();
    endtask

`ifdef INT_SCHED_EXT_EDGE_EN
    task automatic test_ext_edge();
        bus.irq_ext_i = 1; exp_q.push_back(C_MEI);
        tick();
        bus.irq_ext_i = 0;
        vectors++; if (bus.mip_o[11] !== 1'b1) begin miscompares++; $display("FAIL edge_mip_set: got %b want 1", bus.mip_o[11]); end
        tick();
        pop_exp(exp);
        vectors++; if (bus.int_req_o !== 1'b1 || bus.int_cause_o !== exp) begin miscompares++; $display("FAIL edge_req: got %b/%h want 1/%h", bus.int_req_o, bus.int_cause_o, exp); end
        tick(); tick();
        vectors++; if (bus.mip_o[11] !== 1'b1) begin miscompares++; $display("FAIL edge_mip_hold: got %b want 1", bus.mip_o[11]); end
        // New rising edge in the ack cycle: set beats clear
        bus.irq_ext_i = 1; bus.int_ack_i = 1; exp_q.push_back(C_MEI);
        tick(); bus.int_ack_i = 0;
        vectors++; if (bus.mip_o[11] !== 1'b1) begin miscompares++; $display("FAIL edge_set_wins: got %b want 1", bus.mip_o[11]); end
        bus.mret_i = 1; tick(); bus.mret_i = 0;
        tick();
        pop_exp(exp);
        vectors++; if (bus.int_req_o !== 1'b1 || bus.int_cause_o !== exp) begin miscompares++; $display("FAIL edge_second: got %b/%h want 1/%h", bus.int_req_o, bus.int_cause_o, exp); end
        bus.int_ack_i = 1; tick(); bus.int_ack_i = 0;
        vectors++; if (bus.mip_o[11] !== 1'b0) begin miscompares++; $display("FAIL edge_ack_clr: got %b want 0", bus.mip_o[11]); end
        bus.mret_i = 1; tick(); bus.mret_i = 0;
        for (int i = 0; i < 4; i++) tick();
        vectors++; if (bus.int_req_o !== 1'b0) begin miscompares++; $display("FAIL edge_no_rereq: got %b want 0", bus.int_req_o); end
        bus.irq_ext_i = 0; tick();
    endtask
`endif

    initial begin
        test_reset();
        test_timer();
        test_priority();
        test_mie_drop();
        test_preempt_hold();
        test_async_reset();
`ifdef INT_SCHED_EXT_EDGE_EN
        test_ext_edge();
`endif
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/int_sched.md
# int_sched

Machine-mode interrupt scheduler sitting between the interrupt sources (external, software, timer) and the CLINT trap sequencer. It latches pending interrupts into an mip image and masks them with mie and mstatus.MIE. It picks the highest-priority enabled source, presents one stable request with its mcause value to the CLINT, and blocks further requests until the handler returns via mret.

## Interface
Parameters:
- none; all widths are fixed (XLEN = 64).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- irq_ext_i  in  1  machine external interrupt line (MEI)
- irq_sw_i  in  1  machine software interrupt line (MSI)
- irq_timer_i  in  1  machine timer interrupt line (MTI)
- csr_mie  in  64  mie CSR value; bits 11/3/7 used
- csr_mstatus  in  64  mstatus CSR value; bit 3 (MIE) used
- int_ack_i  in  1  single-cycle pulse from CLINT: request accepted, trap sequence started
- mret_i  in  1  single-cycle pulse from CLINT: mret sequence completed
- int_req_o  out  1  interrupt request to CLINT (drives its global_int_en_i)
- int_cause_o  out  64  mcause value for the granted request
- mip_o  out  64  live mip image to csr_regs; bits 11/7/3 only, others 0

## Operation
- Pending latch: every cycle, mip[11] <= irq_ext_i, mip[7] <= irq_timer_i, mip[3] <= irq_sw_i. All sources are level-sensitive (see Configuration for the MEI exception).
- Eligible vector is mip & mie. A request is eligible when csr_mstatus[3] == 1 and the eligible vector is nonzero.
- Priority is fixed: MEI > MSI > MTI.
- Cause encoding: bit 63 = 1, low bits = 11 (MEI), 3 (MSI), 7 (MTI); all other bits 0.
- FSM states:
  - IDLE to REQ when eligible. Register int_req_o = 1 and lock int_cause_o to the winner.
  - REQ to BUSY on int_ack_i. int_req_o drops to 0; int_cause_o is held.
  - REQ to IDLE, with no ack, when eligibility is lost (MIE cleared or the source withdrawn). int_req_o and int_cause_o clear.
  - BUSY to IDLE on mret_i. int_cause_o clears.
- While in REQ, int_cause_o never changes. A higher-priority source arriving mid-REQ waits for the next IDLE.
- Simultaneous events:
  - int_ack_i together with loss of eligibility: ack wins, go to BUSY.
  - mret_i together with an eligible source: go to IDLE only. The new request is raised from IDLE on the next edge.
  - int_ack_i outside REQ, or mret_i outside BUSY: ignored.
- Illegal state encoding: recover to IDLE with outputs cleared.

## Timing
- Reset values: int_req_o = 0, int_cause_o = 0, mip_o = 0, state = IDLE.
- Reset is asynchronous, so all of the above take effect immediately, including mid-REQ or mid-BUSY. No request survives reset.
- Latency: a source first high in cycle N gives mip_o set after edge N+1, and int_req_o = 1 after edge N+2 (when enabled and IDLE).
- int_req_o stays high until the edge that samples int_ack_i = 1. The CLINT samples int_cause_o in the ack cycle.
- Minimum gap between two requests: 1 cycle of IDLE after mret_i.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- INT_SCHED_EXT_EDGE_EN defined:
  - mip[11] is set on a 0-to-1 edge of irq_ext_i, detected with one extra register.
  - mip[11] is cleared on the int_ack_i cycle that grants MEI.
  - Set and clear in the same cycle: set wins.
  - Edge-to-request latency is still 2 cycles.
- INT_SCHED_EXT_EDGE_EN undefined: MEI is level-sensitive like the other sources.

## Structure
- Shared defines file holds: the mip/mie bit positions (11, 7, 3), the mcause codes, the mstatus MIE bit index, and the one-hot FSM state encodings (IDLE = 3'b001, REQ = 3'b010, BUSY = 3'b100).
- Sub-module int_prio_enc: combinational 3-input priority encoder, taking the eligible vector and returning a valid flag and the 64-bit cause. It is instantiated once.

## Test plan
- Reset, then irq_timer_i = 1 with mie[7] = 1 and mstatus[3] = 1 → int_req_o = 1 two cycles later, int_cause_o = 0x8000_0000_0000_0007. Pulse int_ack_i → int_req_o = 0, then mret_i → back to IDLE with int_cause_o = 0.
- irq_ext_i, irq_sw_i and irq_timer_i rise in the same cycle, all enabled → int_cause_o = 0x8000_0000_0000_000B. After ack and mret, the next request has cause 0x…0003, then after the next ack and mret, 0x…0007.
- In REQ, clear mstatus[3] before ack → int_req_o = 0 on the next edge, no ack is needed, and the FSM is in IDLE.
- Timer request pending in REQ, then irq_ext_i rises → int_cause_o stays 0x…0007 until ack. After mret, the next request is MEI (0x…000B).
- Assert rst asynchronously in BUSY → all outputs are 0 immediately. After release with sources still high, a request is re-raised two cycles later.
- With INT_SCHED_EXT_EDGE_EN: a 1-cycle irq_ext_i pulse → mip_o[11] stays set until ack and the request carries 0x…000B. Holding irq_ext_i high after ack produces no second request.
